softmax_feeder: RTL
===================

SOFTMAX_FEEDER -- requirements
Module: softmax_feeder

Interface
REQ-001 SHALL have parameter ROW_LEN, default 64, meaning scores per softmax row (power of 2, 2..1024).
REQ-002 SHALL have parameter DATA_W, default 8, meaning score width on s_data/idata.
REQ-003 SHALL have parameters LUT_ADDR, default 16, and LUT_DATA, default 16, meaning LUT write port address and data widths; LUT_DEPTH = 2**LUT_ADDR.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning watchdog limit in cycles.
REQ-005 SHALL have ports, in this order: clk (in, 1, clock); rst_n (in, 1, reset; one clock, asynchronous active-low reset).
REQ-006 SHALL have LUT load ports: lut_load_start (in, 1, load request pulse); lut_in_valid (in, 1); lut_in_ready (out, 1); lut_in_data (in, LUT_DATA, source entry).
REQ-007 SHALL have LUT write ports: lut_waddr (out, LUT_ADDR); lut_wen (out, 1); lut_wdata (out, LUT_DATA); these drive the softmax LUT write port.
REQ-008 SHALL have score ports: s_valid (in, 1); s_ready (out, 1); s_data (in, DATA_W, upstream score).
REQ-009 SHALL have softmax ports: idata (out, DATA_W); idata_valid (out, 1); odata_valid (in, 1, softmax result strobe).
REQ-010 SHALL have config ports: cfg_shift_in (in, 8); cfg_consmax_shift (out, 8).
REQ-011 SHALL have status ports: busy (out, 1); lut_ready (out, 1); row_done (out, 1, pulse); timeout_err (out, 1, sticky).

Function
REQ-012 SHALL implement states IDLE, LUT_LOAD, FILL, STREAM and WAIT_OUT; busy = (state != IDLE).
REQ-013 IDLE: lut_load_start SHALL move to LUT_LOAD, clear the address counter and clear lut_ready; lut_load_start SHALL be ignored in every other state.
REQ-014 LUT_LOAD: lut_in_ready SHALL be 1; each lut_in handshake SHALL produce, on the next cycle, lut_wen=1, lut_waddr=count and lut_wdata=lut_in_data, then increment count.
REQ-015 After the LUT_DEPTH-th handshake, the block SHALL set lut_ready=1, wrap count to 0 and return to IDLE on the same edge.
REQ-016 s_ready SHALL equal lut_ready AND (state is IDLE, or state is FILL with fewer than ROW_LEN scores accepted); it SHALL be combinational.
REQ-017 In IDLE, a score accept SHALL latch cfg_shift_in into cfg_consmax_shift, store the score at buffer[0] and enter FILL; IDLE with lut_load_start and s_valid both high SHALL take lut_load_start.
REQ-018 FILL SHALL store the accepted scores at buffer[1..ROW_LEN-1] in order; the edge accepting the ROW_LEN-th score SHALL enter STREAM.
REQ-019 STREAM SHALL drive registered idata_valid=1 for exactly ROW_LEN consecutive cycles with idata=buffer[0..ROW_LEN-1], the first in the cycle after the last accept, then enter WAIT_OUT.
REQ-020 odata_valid pulses SHALL be counted in STREAM and WAIT_OUT, and ignored in other states.
REQ-021 When the count reaches ROW_LEN, the block SHALL pulse row_done for 1 cycle on the next cycle and enter IDLE.
REQ-022 idata SHALL hold its last value when idata_valid=0; lut_wen SHALL be a 1-cycle pulse per entry.

Reset
REQ-023 rst_n low SHALL force state IDLE and all counters 0 immediately, and set all outputs to 0, including lut_ready, timeout_err and cfg_consmax_shift.
REQ-024 Buffer contents SHALL NOT be reset; reset mid-LUT_LOAD or mid-row SHALL discard the operation, with no further lut_wen or idata_valid.

Configuration
REQ-025 With SOFTMAX_FEEDER_TIMEOUT_EN defined, a watchdog SHALL clear on entering WAIT_OUT and on each odata_valid.
REQ-026 With the macro defined, reaching TIMEOUT_CYC cycles in WAIT_OUT SHALL set sticky timeout_err (cleared only by reset), pulse row_done and enter IDLE.
REQ-027 With the macro undefined, WAIT_OUT SHALL wait indefinitely and timeout_err SHALL be tied 0.

Verification
REQ-028 LUT_ADDR=4, load 16 entries 0x1000+i with random valid gaps -> 16 lut_wen pulses, addr 0..15, data 0x1000..0x100F, lut_ready=1 after the last.
REQ-029 lut_ready=0, s_valid=1 -> s_ready stays 0, no state change, busy=0.
REQ-030 ROW_LEN=8, scores 0x01..0x08 with gaps, cfg_shift_in=5 -> idata 01..08 on 8 consecutive cycles starting 1 cycle after the 8th accept, cfg_consmax_shift=5.
REQ-031 8 odata_valid pulses during STREAM/WAIT_OUT -> row_done 1 cycle after the 8th, busy=0, next row is accepted.
REQ-032 Macro defined, TIMEOUT_CYC=16, only 3 pulses returned -> timeout_err=1 and row_done 16 cycles after the 3rd pulse; macro undefined -> remains in WAIT_OUT.
REQ-033 rst_n low on the 4th STREAM cycle -> idata_valid=0 and busy=0 immediately, lut_ready=0, no row_done.

Source files
------------

// File: rtl/softmax_feeder.sv
// Softmax front end: loads the exp LUT, buffers one row of scores, streams it and waits for results.
// Define SOFTMAX_FEEDER_TIMEOUT_EN to add a watchdog on the result-collection phase.
module softmax_feeder #(
    parameter int unsigned ROW_LEN     = 64,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned LUT_ADDR    = 16,
    parameter int unsigned LUT_DATA    = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lut_load_start,
    input  logic                lut_in_valid,
    output logic                lut_in_ready,
    input  logic [LUT_DATA-1:0] lut_in_data,
    output logic [LUT_ADDR-1:0] lut_waddr,
    output logic                lut_wen,
    output logic [LUT_DATA-1:0] lut_wdata,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic [DATA_W-1:0]   idata,
    output logic                idata_valid,
    input  logic                odata_valid,
    input  logic [7:0]          cfg_shift_in,
    output logic [7:0]          cfg_consmax_shift,
    output logic                busy,
    output logic                lut_ready,
    output logic                row_done,
    output logic                timeout_err
);

    localparam int unsigned IDX_W = $clog2(ROW_LEN);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]    ROW_LAST = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0]    ROW_FULL = CNT_W'(ROW_LEN);
    localparam logic [LUT_ADDR-1:0] LUT_LAST = '1;

    typedef enum logic [2:0] {StIdle, StLutLoad, StFill, StStream, StWaitOut} state_e;

    state_e                state_q;
    logic [LUT_ADDR-1:0]   lut_cnt_q;
    logic                  lut_wen_q;
    logic [LUT_ADDR-1:0]   lut_waddr_q;
    logic [LUT_DATA-1:0]   lut_wdata_q;
    logic                  lut_ready_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      ocnt_q;
    logic [DATA_W-1:0]     idata_q;
    logic                  idata_valid_q;
    logic                  row_done_q;
    logic [7:0]            shift_q;
    logic [DATA_W-1:0]     buf_q [ROW_LEN];

`ifdef SOFTMAX_FEEDER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
`endif

    logic             lut_hs;
    logic             s_hs;
    logic             res_phase;
    logic             ocnt_en;
    logic [CNT_W-1:0] ocnt_nxt;
    logic             out_done;
    logic [IDX_W-1:0] wr_idx;

    always_comb begin
        lut_hs    = (state_q == StLutLoad) && lut_in_valid;
        // A pending LUT load wins over a score in IDLE, so the score is not acknowledged.
        s_ready   = lut_ready_q &&
                    (((state_q == StIdle) && !lut_load_start) ||
                     ((state_q == StFill) && (cnt_q < ROW_FULL)));
        s_hs      = s_valid && s_ready;
        res_phase = (state_q == StStream) || (state_q == StWaitOut);
        ocnt_en   = odata_valid && res_phase && (ocnt_q != ROW_FULL);
        ocnt_nxt  = ocnt_q + CNT_W'(ocnt_en);
        out_done  = (ocnt_nxt == ROW_FULL);
        wr_idx    = (state_q == StIdle) ? '0 : cnt_q[IDX_W-1:0];
    end

    // Score storage is never reset; contents are only meaningful after a full row is filled.
    always_ff @(posedge clk) begin
        if (s_hs) begin
            buf_q[wr_idx] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            lut_cnt_q     <= '0;
            lut_wen_q     <= 1'b0;
            lut_waddr_q   <= '0;
            lut_wdata_q   <= '0;
            lut_ready_q   <= 1'b0;
            cnt_q         <= '0;
            ocnt_q        <= '0;
            idata_q       <= '0;
            idata_valid_q <= 1'b0;
            row_done_q    <= 1'b0;
            shift_q       <= '0;
`ifdef SOFTMAX_FEEDER_TIMEOUT_EN
            wd_q          <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            lut_wen_q  <= lut_hs;
            row_done_q <= 1'b0;
            if (lut_hs) begin
                lut_waddr_q <= lut_cnt_q;
                lut_wdata_q <= lut_in_data;
                lut_cnt_q   <= lut_cnt_q + LUT_ADDR'(1);
            end
            if (res_phase) begin
                ocnt_q <= ocnt_nxt;
            end
            unique case (state_q)
                StIdle: begin
                    if (lut_load_start) begin
                        state_q     <= StLutLoad;
                        lut_cnt_q   <= '0;
                        lut_ready_q <= 1'b0;
                    end else if (s_hs) begin
                        shift_q <= cfg_shift_in;
                        cnt_q   <= CNT_W'(1);
                        ocnt_q  <= '0;
                        state_q <= StFill;
                    end
                end
                StLutLoad: begin
                    if (lut_hs && (lut_cnt_q == LUT_LAST)) begin
                        lut_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StFill: begin
                    if (s_hs) begin
                        if (cnt_q == ROW_LAST) begin
                            idata_q       <= buf_q[0];
                            idata_valid_q <= 1'b1;
                            cnt_q         <= CNT_W'(1);
                            state_q       <= StStream;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StStream: begin
                    if (cnt_q == ROW_FULL) begin
                        idata_valid_q <= 1'b0;
                        if (out_done) begin
                            state_q    <= StIdle;
                            row_done_q <= 1'b1;
                            ocnt_q     <= '0;
                        end else begin
                            state_q <= StWaitOut;
`ifdef SOFTMAX_FEEDER_TIMEOUT_EN
                            wd_q    <= '0;
`endif
                        end
                    end else begin
                        idata_q <= buf_q[cnt_q[IDX_W-1:0]];
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                StWaitOut: begin
                    if (out_done) begin
                        state_q    <= StIdle;
                        row_done_q <= 1'b1;
                        ocnt_q     <= '0;
                    end
`ifdef SOFTMAX_FEEDER_TIMEOUT_EN
                    else if (!odata_valid && (wd_q == WD_LAST)) begin
                        state_q    <= StIdle;
                        row_done_q <= 1'b1;
                        ocnt_q     <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        wd_q <= odata_valid ? '0 : wd_q + WD_W'(1);
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lut_in_ready      = (state_q == StLutLoad);
    assign lut_waddr         = lut_waddr_q;
    assign lut_wen           = lut_wen_q;
    assign lut_wdata         = lut_wdata_q;
    assign idata             = idata_q;
    assign idata_valid       = idata_valid_q;
    assign cfg_consmax_shift = shift_q;
    assign busy              = (state_q != StIdle);
    assign lut_ready         = lut_ready_q;
    assign row_done          = row_done_q;

`ifdef SOFTMAX_FEEDER_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_err        = 1'b0;
`endif

endmodule
